ram_arbiter: RTL and testbench

Dual-core shared-RAM arbiter. It sits between the four cache-side requesters (icache0, dcache0, icache1, dcache1) and the single-ported RAM model. It grants one requester at a time with round-robin fairness and holds the grant until the RAM reports ACCESS or ERROR. It also generates the per-requester wait handshakes and broadcasts RAM load data.

---
 rtl/ram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter between four cache requesters
// (i0, d0, i1, d1) and a single-ported RAM. The grant is held until
// the RAM reports ACCESS or ERROR, or until the requester drops.
// Ports: CLK, RST (sync, active-high); iREN/iaddr, dREN/dWEN/daddr/
// dstore per core; iwait/dwait stalls; iload/dload broadcast of
// ramload; ramaddr/ramstore/ramREN/ramWEN to the RAM; ramstate in;
// gnt_valid/gnt_id grant status; err one-cycle ERROR pulse.
// Option: define ARB_DPRIO_EN to scan data requesters before
// instruction requesters.
module ram_arbiter #(
  parameter int WORDW = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            iREN,
  input  logic [1:0][WORDW-1:0] iaddr,
  input  logic [1:0]            dREN,
  input  logic [1:0]            dWEN,
  input  logic [1:0][WORDW-1:0] daddr,
  input  logic [1:0][WORDW-1:0] dstore,
  output logic [1:0]            iwait,
  output logic [1:0]            dwait,
  output logic [1:0][WORDW-1:0] iload,
  output logic [1:0][WORDW-1:0] dload,
  output logic [WORDW-1:0]      ramaddr,
  output logic [WORDW-1:0]      ramstore,
  output logic                  ramREN,
  output logic                  ramWEN,
  input  logic [WORDW-1:0]      ramload,
  input  logic [1:0]            ramstate,
  output logic                  gnt_valid,
  output logic [1:0]            gnt_id,
  output logic                  err
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] last_q, last_d;
  logic       err_q, err_d;

  // requester id: bit0 = data port, bit1 = core
  logic [3:0] req;
  logic       g_act;
  logic       g_core;
  logic       g_is_d;
  logic [1:0] win;
  logic       found;
  logic [1:0] idx;

  assign req[0] = iREN[0];
  assign req[1] = dREN[0] | dWEN[0];
  assign req[2] = iREN[1];
  assign req[3] = dREN[1] | dWEN[1];

  assign g_act  = req[gnt_q];
  assign g_core = gnt_q[1];
  assign g_is_d = gnt_q[0];

  // scan last+1 .. last+4 (mod 4)
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = last_q;
`ifdef ARB_DPRIO_EN
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx] && idx[0]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx] && !idx[0]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`else
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      last_q  <= 2'd3;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // abort outranks ACCESS/ERROR; abort leaves last untouched
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = win;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!g_act) begin
          state_d = IDLE;
        end else if (ramstate == RS_ACCESS) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end else if (ramstate == RS_ERROR) begin
          last_d  = gnt_q;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    iwait    = 2'b11;
    dwait    = 2'b11;
    if (state_q == ACTIVE) begin
      if (g_is_d) begin
        ramaddr  = daddr[g_core];
        ramstore = dstore[g_core];
        ramWEN   = dWEN[g_core];
        ramREN   = dREN[g_core] & ~dWEN[g_core];
        if (g_act && ramstate == RS_ACCESS)
          dwait[g_core] = 1'b0;
      end else begin
        ramaddr = iaddr[g_core];
        ramREN  = iREN[g_core];
        if (g_act && ramstate == RS_ACCESS)
          iwait[g_core] = 1'b0;
      end
    end
  end

  assign iload     = {ramload, ramload};
  assign dload     = {ramload, ramload};
  assign gnt_valid = (state_q == ACTIVE);
  assign gnt_id    = gnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus randomized traffic for
// ram_arbiter, checked against a grant/fairness reference model.
module tb_ram_arbiter;

  logic             CLK = 1'b0;
  logic             RST;
  logic [1:0]       iREN, dREN, dWEN;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait;
  logic [1:0][31:0] iload, dload;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic             ramREN, ramWEN;
  logic [1:0]       ramstate;
  logic             gnt_valid;
  logic [1:0]       gnt_id;
  logic             err;

  int checks = 0;
  int errors = 0;

  bit m_init = 0;
  bit m_act, m_err;
  int m_gnt, m_last;

  ram_arbiter #(.WORDW(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id),
    .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit mact(int id);
    int c = id / 2;
    if (id % 2 == 0) return iREN[c];
    return dREN[c] | dWEN[c];
  endfunction

  function automatic int m_win();
    for (int p = 0; p < 2; p++)
      for (int k = 1; k <= 4; k++) begin
        int id = (m_last + k) % 4;
        bit ok;
`ifdef ARB_DPRIO_EN
        ok = (p == 0) ? (id % 2 == 1) : (id % 2 == 0);
`else
        ok = (p == 0);
`endif
        if (ok && mact(id)) return id;
      end
    return -1;
  endfunction

  // settle, then compare every output with the model
  task automatic step();
    logic [31:0] ea, es;
    logic        er, ew;
    logic [1:0]  eiw, edw;
    int c;
    #1;
    if (m_init) begin
      ea = 0; es = 0; er = 0; ew = 0;
      eiw = 2'b11; edw = 2'b11;
      c = m_gnt / 2;
      if (m_act) begin
        if (m_gnt % 2 == 1) begin
          ea = daddr[c]; es = dstore[c];
          ew = dWEN[c];
          er = dREN[c] && !dWEN[c];
          if (mact(m_gnt) && ramstate == 2) edw[c] = 1'b0;
        end else begin
          ea = iaddr[c];
          er = iREN[c];
          if (mact(m_gnt) && ramstate == 2) eiw[c] = 1'b0;
        end
      end
      chk("gnt_valid", 64'(gnt_valid), 64'(m_act));
      chk("gnt_id", 64'(gnt_id), 64'(m_gnt));
      chk("ramaddr", 64'(ramaddr), 64'(ea));
      chk("ramstore", 64'(ramstore), 64'(es));
      chk("ramREN", 64'(ramREN), 64'(er));
      chk("ramWEN", 64'(ramWEN), 64'(ew));
      chk("iwait", 64'(iwait), 64'(eiw));
      chk("dwait", 64'(dwait), 64'(edw));
      chk("err", 64'(err), 64'(m_err));
      chk("iload", 64'(iload), {ramload, ramload});
      chk("dload", 64'(dload), {ramload, ramload});
    end
  endtask

  task automatic tick();
    int w;
    @(posedge CLK);
    if (RST) begin
      m_act = 0; m_gnt = 0; m_last = 3; m_err = 0;
      m_init = 1;
    end else if (m_init) begin
      m_err = 0;
      if (!m_act) begin
        w = m_win();
        if (w >= 0) begin
          m_gnt = w;
          m_act = 1;
        end
      end else if (!mact(m_gnt)) begin
        m_act = 0;
      end else if (ramstate == 2) begin
        m_last = m_gnt;
        m_act = 0;
      end else if (ramstate == 3) begin
        m_last = m_gnt;
        m_act = 0;
        m_err = 1;
      end
    end
    @(negedge CLK);
  endtask

  task automatic clr();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = 2'd0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clr();
    step();
    tick();
    RST = 1'b0;
  endtask

  int exp_g;

  initial begin
    RST = 1'b1;
    ramload = 32'h1234_5678;
    clr();
    @(negedge CLK);

    // reset state, then single i0 fetch
    do_reset();
    step();
    chk("rst_gv", 64'(gnt_valid), 64'd0);
    chk("rst_iw", 64'(iwait), 64'h3);
    chk("rst_dw", 64'(dwait), 64'h3);
    chk("rst_ren", 64'(ramREN), 64'd0);
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = 2'd1;
    step();
    chk("t1_idle", 64'(gnt_valid), 64'd0);
    tick();
    step();
    chk("t1_gid", 64'(gnt_id), 64'd0);
    chk("t1_addr", 64'(ramaddr), 64'h40);
    chk("t1_ren", 64'(ramREN), 64'd1);
    tick();
    ramstate = 2'd2;
    step();
    chk("t1_iw", 64'(iwait), 64'h2);
    tick();
    iREN = 0; ramstate = 2'd0;
    step();
    chk("t1_back", 64'(gnt_valid), 64'd0);
    tick();

    // d1 read+write: write wins
    do_reset();
    dREN = 2'b10; dWEN = 2'b10;
    daddr[1] = 32'h100; dstore[1] = 32'hDEADBEEF;
    ramstate = 2'd1;
    step(); tick();
    step();
    chk("t3_gid", 64'(gnt_id), 64'd3);
    chk("t3_wen", 64'(ramWEN), 64'd1);
    chk("t3_ren", 64'(ramREN), 64'd0);
    chk("t3_st", 64'(ramstore), 64'hDEADBEEF);
    tick();
    ramstate = 2'd2;
    step();
    chk("t3_dw", 64'(dwait), 64'h1);
    tick();
    clr();
    step(); tick();

    // i1 ERROR then retry after other pending requesters
    do_reset();
    iREN = 2'b10; ramstate = 2'd1;
    step(); tick();
    iREN = 2'b11; dREN = 2'b10; ramstate = 2'd3;
    step();
    chk("t4_gid", 64'(gnt_id), 64'd2);
    chk("t4_iw", 64'(iwait), 64'h3);
    tick();
    ramstate = 2'd1;
    step();
    chk("t4_err", 64'(err), 64'd1);
    tick();
    ramstate = 2'd2;
    step();
    chk("t4_g2", 64'(gnt_id), 64'd3);
    tick();
    dREN = 0;
    step();
    chk("t4_err0", 64'(err), 64'd0);
    tick();
    step();
    chk("t4_g3", 64'(gnt_id), 64'd0);
    tick();
    iREN = 2'b10;
    step(); tick();
    step();
    chk("t4_retry", 64'(gnt_id), 64'd2);
    tick();
    clr();
    step(); tick();

    // abort by d0 keeps last
    do_reset();
    iREN = 2'b01; ramstate = 2'd2;
    step(); tick();
    step(); tick();
    iREN = 0; dREN = 2'b01; ramstate = 2'd1;
    step(); tick();
    dREN = 0;
    step();
    chk("t5_gid", 64'(gnt_id), 64'd1);
    chk("t5_dw", 64'(dwait), 64'h3);
    tick();
    dREN = 2'b01; iREN = 2'b10;
    step();
    chk("t5_idle", 64'(gnt_valid), 64'd0);
    tick();
    step();
    chk("t5_regnt", 64'(gnt_id), 64'd1);
    tick();
    clr();
    step(); tick();

    // reset while ACTIVE
    do_reset();
    iREN = 2'b10; ramstate = 2'd1;
    step(); tick();
    RST = 1'b1;
    step(); tick();
    RST = 1'b0;
    step();
    chk("t6_gv", 64'(gnt_valid), 64'd0);
    chk("t6_iw", 64'(iwait), 64'h3);
    chk("t6_ren", 64'(ramREN), 64'd0);
    iREN = 2'b11; dREN = 2'b11;
    tick();
    step();
`ifdef ARB_DPRIO_EN
    chk("t6_first", 64'(gnt_id), 64'd1);
`else
    chk("t6_first", 64'(gnt_id), 64'd0);
`endif
    tick();

    // all four busy, RAM always ACCESS
    do_reset();
    iREN = 2'b11; dREN = 2'b11; ramstate = 2'd2;
    for (int c = 0; c < 16; c++) begin
      step();
      if (c % 2 == 1) begin
`ifdef ARB_DPRIO_EN
        exp_g = ((c / 2) % 2 == 1) ? 3 : 1;
        chk("rr_iw", 64'(iwait), 64'h3);
`else
        exp_g = (c / 2) % 4;
`endif
        chk("rr_gid", 64'(gnt_id), 64'(exp_g));
        chk("rr_gv", 64'(gnt_valid), 64'd1);
      end
      tick();
    end

    // randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 3) == 0) iREN[c] = ~iREN[c];
        if ($urandom_range(0, 3) == 0) dREN[c] = ~dREN[c];
        if ($urandom_range(0, 5) == 0) dWEN[c] = ~dWEN[c];
        iaddr[c] = $urandom();
        daddr[c] = $urandom();
        dstore[c] = $urandom();
      end
      ramstate = 2'($urandom_range(0, 3));
      ramload = $urandom();
      RST = ($urandom_range(0, 99) == 0);
      step();
      tick();
    end
    RST = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
